tensor_rd_arbiter: RTL and testbench
====================================

Name: tensor_rd_arbiter

Overview:
- Shares the single AXI read request/return path of the tensor core among NREQ operand fetchers (default A, B and C/accumulator loaders).
- Picks one pending fetch request with round-robin arbitration and issues it as one burst request.
- Tracks outstanding bursts in issue order and steers each returned beat back to the fetcher that owns it.
- Sits between the tensorcore fetch sequencers and axi_tensor_rd.

Parameters:
NREQ, 3, number of requesters (index 0..NREQ-1)
ADDR_WIDTH, 32, burst base address width
DATA_WIDTH, 256, beat width
MAX_OUT, 4, maximum outstanding bursts (power of 2, ≥2)

Ports:
clk  in  1  clock
aresetn  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester burst request
req_ready  out  NREQ  request accepted this cycle (one-hot or zero)
req_base  in  NREQ*ADDR_WIDTH  per-requester base address
req_burst_num  in  NREQ*6  per-requester beats minus one
req_burst_size  in  NREQ*3  per-requester AXI size code
rsp_valid  out  NREQ  one-hot beat valid to owning requester
rsp_last  out  NREQ  one-hot last beat of owned burst
rsp_data  out  DATA_WIDTH  shared beat data
axi_out_request_valid  out  1  burst request to axi_tensor_rd
axi_out_BASE  out  32  request base
axi_out_burst_num  out  6  request beats minus one
axi_out_burst_size  out  3  request size
axi_out_sel  out  3  requester index of issued burst
axi_in_arready  in  1  axi_tensor_rd accepts request
axi_in_valid  in  1  return beat valid
axi_in_finish  in  1  return beat is last of burst
axi_in_data  in  DATA_WIDTH  return beat data
axi_in_burst_id  in  32  sequence number of returning burst
outstanding  out  clog2(MAX_OUT)+1  bursts issued, not yet finished
id_err  out  1  sticky burst-id mismatch flag
busy  out  1  request pending or outstanding≠0

Behaviour:
- Reset (async, aresetn=0): all outputs 0; rr pointer=0; issue_seq=0; expect_seq=0; order FIFO empty; state IDLE. Any in-flight request or burst is dropped. The bench deasserts aresetn only with AXI side quiet.
- FSM IDLE: when any req_valid and outstanding<MAX_OUT, grant the first valid index at or after the rr pointer. Latch that requester's base/num/size and index. Go to ISSUE. The latch cycle asserts req_ready[grant] (request accepted, requester may drop it).
- ISSUE: axi_out_request_valid=1 with latched fields; axi_out_sel=grant index. Fields stay stable until axi_in_arready.
- On valid&&arready: push the index into the order FIFO, issue_seq++, rr pointer=grant+1 mod NREQ, go to IDLE. The earliest next grant is the following cycle, giving max 1 request per 2 cycles.
- With outstanding==MAX_OUT, IDLE grants nothing and req_ready stays 0.
- Return path, combinational from the FIFO head:
  - rsp_valid[head]=axi_in_valid.
  - rsp_last[head]=axi_in_valid&&axi_in_finish.
  - rsp_data=axi_in_data.
  - Zero-latency passthrough; requesters always accept.
- On valid&&finish: pop the FIFO and expect_seq++.
- On any valid beat: if axi_in_burst_id[clog2(MAX_OUT)-1:0]≠expect_seq low bits, set id_err (sticky until reset). Data is still routed to the head.
- Beat with FIFO empty: ignored, id_err set.
- outstanding = pushes − pops. Push and pop in the same cycle leaves it unchanged. A pop into the full state frees a slot the next cycle.
- A requester deasserting req_valid before req_ready is legal; it is simply not granted.
- busy = (state≠IDLE) | (outstanding≠0) | (|req_valid).

Test Plan:
- Single request: req_valid[1], base 0x1000, num 7, arready after 3 cycles → axi_out_request_valid stable 3 cycles with BASE 0x1000, num 7, sel 1. Then 8 beats appear on rsp_valid[1] only, rsp_last[1] on the 8th, outstanding returns 1→0.
- Round robin: req_valid=3'b111 held, arready=1 → grants in order 0,1,2,0. req_ready fires one-hot every 2 cycles.
- Backpressure at limit: issue 4 bursts without returns → outstanding=4, further req_ready=0. One finish → next grant within 2 cycles.
- Interleaved order: issue sel 2 then 0, return burst id 0 (4 beats) then id 1 → beats steered to rsp_valid[2], then rsp_valid[0]; id_err=0.
- Simultaneous push/pop: arready handshake in the same cycle as finish with outstanding=2 → outstanding stays 2.
- Error/reset: return beat with burst_id 3 when expecting 0 → id_err=1 and stays set. Assert aresetn=0 mid-ISSUE → all outputs 0 immediately, outstanding=0, id_err=0.

Source files
------------

// File: rtl/tensor_rd_arbiter.sv
// Round-robin arbiter sharing one AXI burst-read path among NREQ operand fetchers.
// Outstanding bursts are tracked in issue order so that returned beats go back to the requester that owns them.
module tensor_rd_arbiter #(
    parameter int NREQ       = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256,
    parameter int MAX_OUT    = 4
) (
    input  logic                       clk,
    input  logic                       aresetn,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_base,
    input  logic [NREQ*6-1:0]          req_burst_num,
    input  logic [NREQ*3-1:0]          req_burst_size,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [NREQ-1:0]            rsp_last,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic                       axi_out_request_valid,
    output logic [ADDR_WIDTH-1:0]      axi_out_BASE,
    output logic [5:0]                 axi_out_burst_num,
    output logic [2:0]                 axi_out_burst_size,
    output logic [2:0]                 axi_out_sel,
    input  logic                       axi_in_arready,
    input  logic                       axi_in_valid,
    input  logic                       axi_in_finish,
    input  logic [DATA_WIDTH-1:0]      axi_in_data,
    input  logic [31:0]                axi_in_burst_id,
    output logic [$clog2(MAX_OUT):0]   outstanding,
    output logic                       id_err,
    output logic                       busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW = $clog2(MAX_OUT);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                  state, next_state;
    logic [IW-1:0]           rr_ptr, grant_idx, pick, cand;
    logic                    found, can_grant, push, pop, fifo_empty, id_bad;
    logic [ADDR_WIDTH-1:0]   lat_base;
    logic [5:0]              lat_num;
    logic [2:0]              lat_size;
    logic [IW-1:0]           order_fifo [MAX_OUT];
    logic [PW-1:0]           issue_seq, expect_seq;
    logic [CW-1:0]           count;
    logic [IW-1:0]           head;
    logic                    id_err_q;
    logic                    unused_id_bits;

    assign unused_id_bits = ^axi_in_burst_id[31:PW];

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IW'((32'(rr_ptr) + i) % 32'(NREQ));
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign fifo_empty = (count == '0);
    assign can_grant  = (state == IDLE) && found && (count < CW'(MAX_OUT)) && aresetn;
    assign push       = (state == ISSUE) && axi_in_arready;
    assign pop        = axi_in_valid && axi_in_finish && !fifo_empty;
    assign head       = order_fifo[expect_seq];
    assign id_bad     = axi_in_valid && (fifo_empty || (axi_in_burst_id[PW-1:0] != expect_seq));

    always_comb begin
        next_state = state;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (can_grant) begin
                    req_ready[pick] = 1'b1;
                    next_state      = ISSUE;
                end
            end
            ISSUE: begin
                if (axi_in_arready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        rsp_valid = '0;
        rsp_last  = '0;
        if (axi_in_valid && !fifo_empty) begin
            rsp_valid[head] = 1'b1;
            rsp_last[head]  = axi_in_finish;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_idx  <= '0;
            lat_base   <= '0;
            lat_num    <= '0;
            lat_size   <= '0;
            issue_seq  <= '0;
            expect_seq <= '0;
            count      <= '0;
            id_err_q   <= 1'b0;
        end else begin
            state <= next_state;
            if (can_grant) begin
                grant_idx <= pick;
                lat_base  <= req_base[pick*ADDR_WIDTH +: ADDR_WIDTH];
                lat_num   <= req_burst_num[pick*6 +: 6];
                lat_size  <= req_burst_size[pick*3 +: 3];
            end
            if (push) begin
                issue_seq <= issue_seq + PW'(1);
                rr_ptr    <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
            end
            if (pop) expect_seq <= expect_seq + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (id_bad) id_err_q <= 1'b1;
        end
    end

    // Storage needs no reset: entries are only read while count marks them valid.
    always_ff @(posedge clk) begin
        if (push) order_fifo[issue_seq] <= grant_idx;
    end

    assign rsp_data              = axi_in_data;
    assign axi_out_request_valid = (state == ISSUE);
    assign axi_out_BASE          = lat_base;
    assign axi_out_burst_num     = lat_num;
    assign axi_out_burst_size    = lat_size;
    assign axi_out_sel           = 3'(grant_idx);
    assign outstanding           = count;
    assign id_err                = id_err_q;
    assign busy                  = (state != IDLE) || (count != '0) || (|req_valid);

endmodule

// File: tb/tb_tensor_rd_arbiter.sv
// Directed table-driven bench for tensor_rd_arbiter: one row per clock cycle of inputs and expected outputs.
// Hand-written sequences cover the reset-state and asynchronous mid-ISSUE reset cases.
module tb_tensor_rd_arbiter;

    logic           clk = 1'b0;
    logic           aresetn = 1'b0;
    logic [2:0]     req_valid = '0;
    logic [2:0]     req_ready;
    logic [95:0]    req_base;
    logic [17:0]    req_burst_num;
    logic [8:0]     req_burst_size;
    logic [2:0]     rsp_valid, rsp_last;
    logic [255:0]   rsp_data;
    logic           axi_out_request_valid;
    logic [31:0]    axi_out_BASE;
    logic [5:0]     axi_out_burst_num;
    logic [2:0]     axi_out_burst_size, axi_out_sel;
    logic           axi_in_arready = 1'b0, axi_in_valid = 1'b0, axi_in_finish = 1'b0;
    logic [255:0]   axi_in_data = '0;
    logic [31:0]    axi_in_burst_id = '0;
    logic [2:0]     outstanding;
    logic           id_err, busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] bases [3] = '{32'h0000_0100, 32'h0000_1000, 32'h0000_2200};
    logic [5:0]  nums  [3] = '{6'd3, 6'd7, 6'd1};
    logic [2:0]  sizes [3] = '{3'd5, 3'd5, 3'd4};

    assign req_base       = {bases[2], bases[1], bases[0]};
    assign req_burst_num  = {nums[2], nums[1], nums[0]};
    assign req_burst_size = {sizes[2], sizes[1], sizes[0]};

    always #5 clk = ~clk;

    tensor_rd_arbiter #(.NREQ(3), .ADDR_WIDTH(32), .DATA_WIDTH(256), .MAX_OUT(4)) dut (
        .clk(clk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_base(req_base),
        .req_burst_num(req_burst_num), .req_burst_size(req_burst_size),
        .rsp_valid(rsp_valid), .rsp_last(rsp_last), .rsp_data(rsp_data),
        .axi_out_request_valid(axi_out_request_valid), .axi_out_BASE(axi_out_BASE),
        .axi_out_burst_num(axi_out_burst_num), .axi_out_burst_size(axi_out_burst_size),
        .axi_out_sel(axi_out_sel), .axi_in_arready(axi_in_arready),
        .axi_in_valid(axi_in_valid), .axi_in_finish(axi_in_finish),
        .axi_in_data(axi_in_data), .axi_in_burst_id(axi_in_burst_id),
        .outstanding(outstanding), .id_err(id_err), .busy(busy)
    );

    typedef struct {
        bit          rst;
        logic [2:0]  rv;
        logic        ar, iv, fin;
        logic [31:0] bid;
        logic [2:0]  rdy;
        logic        aval;
        logic [2:0]  sel;
        logic [2:0]  outst;
        logic [2:0]  rspv, rspl;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rst, input logic [2:0] rv, input logic ar, input logic iv,
                       input logic fin, input logic [31:0] bid, input logic [2:0] rdy,
                       input logic aval, input logic [2:0] sel, input logic [2:0] outst,
                       input logic [2:0] rspv, input logic [2:0] rspl, input logic err);
        tbl.push_back('{rst, rv, ar, iv, fin, bid, rdy, aval, sel, outst, rspv, rspl, err});
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
        end
    endtask

    task automatic quiet_inputs();
        req_valid       = '0;
        axi_in_arready  = 1'b0;
        axi_in_valid    = 1'b0;
        axi_in_finish   = 1'b0;
        axi_in_burst_id = '0;
        axi_in_data     = '0;
    endtask

    task automatic do_reset(input int row);
        #1;
        aresetn = 1'b0;
        quiet_inputs();
        #1;
        chk("reset_outputs", row,
            {19'd0, req_ready, axi_out_request_valid, outstanding, id_err, busy, rsp_valid},
            32'd0);
        chk("reset_sel_base", row, {axi_out_sel, 26'd0} | axi_out_BASE, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        aresetn = 1'b1;
    endtask

    initial begin
        vec_t v;
        logic [255:0] dpat;
        logic         exp_busy;

        // Single request from requester 1, arready after 3 cycles, 8-beat return.
        add(1, 3'b010, 0, 0, 0, 0, 3'b010, 0, 0, 0, 3'b000, 3'b000, 0);
        add(0, 3'b000, 0, 0, 0, 0, 3'b000, 1, 1, 0, 3'b000, 3'b000, 0);
        add(0, 3'b000, 0, 0, 0, 0, 3'b000, 1, 1, 0, 3'b000, 3'b000, 0);
        add(0, 3'b000, 1, 0, 0, 0, 3'b000, 1, 1, 0, 3'b000, 3'b000, 0);
        for (int k = 0; k < 7; k++)
            add(0, 3'b000, 0, 1, 0, 0, 3'b000, 0, 0, 1, 3'b010, 3'b000, 0);
        add(0, 3'b000, 0, 1, 1, 0, 3'b000, 0, 0, 1, 3'b010, 3'b010, 0);
        add(0, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 3'b000, 0);

        // Round robin 0,1,2,0, stall at MAX_OUT, one finish frees a slot, then drain.
        add(1, 3'b111, 1, 0, 0, 0, 3'b001, 0, 0, 0, 3'b000, 3'b000, 0);
        add(0, 3'b111, 1, 0, 0, 0, 3'b000, 1, 0, 0, 3'b000, 3'b000, 0);
        add(0, 3'b111, 1, 0, 0, 0, 3'b010, 0, 0, 1, 3'b000, 3'b000, 0);
        add(0, 3'b111, 1, 0, 0, 0, 3'b000, 1, 1, 1, 3'b000, 3'b000, 0);
        add(0, 3'b111, 1, 0, 0, 0, 3'b100, 0, 0, 2, 3'b000, 3'b000, 0);
        add(0, 3'b111, 1, 0, 0, 0, 3'b000, 1, 2, 2, 3'b000, 3'b000, 0);
        add(0, 3'b111, 1, 0, 0, 0, 3'b001, 0, 0, 3, 3'b000, 3'b000, 0);
        add(0, 3'b111, 1, 0, 0, 0, 3'b000, 1, 0, 3, 3'b000, 3'b000, 0);
        add(0, 3'b111, 1, 0, 0, 0, 3'b000, 0, 0, 4, 3'b000, 3'b000, 0);
        add(0, 3'b111, 1, 0, 0, 0, 3'b000, 0, 0, 4, 3'b000, 3'b000, 0);
        add(0, 3'b111, 1, 1, 1, 0, 3'b000, 0, 0, 4, 3'b001, 3'b001, 0);
        add(0, 3'b111, 1, 0, 0, 0, 3'b010, 0, 0, 3, 3'b000, 3'b000, 0);
        add(0, 3'b000, 1, 0, 0, 0, 3'b000, 1, 1, 3, 3'b000, 3'b000, 0);
        add(0, 3'b000, 0, 1, 1, 1, 3'b000, 0, 0, 4, 3'b010, 3'b010, 0);
        add(0, 3'b000, 0, 1, 1, 2, 3'b000, 0, 0, 3, 3'b100, 3'b100, 0);
        add(0, 3'b000, 0, 1, 1, 3, 3'b000, 0, 0, 2, 3'b001, 3'b001, 0);
        add(0, 3'b000, 0, 1, 1, 32'h104, 3'b000, 0, 0, 1, 3'b010, 3'b010, 0);
        add(0, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 3'b000, 0);

        // Interleaved owners (2 then 0) with push and pop landing in the same cycle.
        add(1, 3'b100, 1, 0, 0, 0, 3'b100, 0, 0, 0, 3'b000, 3'b000, 0);
        add(0, 3'b000, 1, 0, 0, 0, 3'b000, 1, 2, 0, 3'b000, 3'b000, 0);
        add(0, 3'b001, 1, 0, 0, 0, 3'b001, 0, 0, 1, 3'b000, 3'b000, 0);
        add(0, 3'b000, 1, 0, 0, 0, 3'b000, 1, 0, 1, 3'b000, 3'b000, 0);
        add(0, 3'b010, 0, 1, 0, 0, 3'b010, 0, 0, 2, 3'b100, 3'b000, 0);
        add(0, 3'b000, 0, 1, 0, 0, 3'b000, 1, 1, 2, 3'b100, 3'b000, 0);
        add(0, 3'b000, 0, 1, 0, 0, 3'b000, 1, 1, 2, 3'b100, 3'b000, 0);
        add(0, 3'b000, 1, 1, 1, 0, 3'b000, 1, 1, 2, 3'b100, 3'b100, 0);
        add(0, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 2, 3'b000, 3'b000, 0);
        add(0, 3'b000, 0, 1, 0, 1, 3'b000, 0, 0, 2, 3'b001, 3'b000, 0);
        add(0, 3'b000, 0, 1, 1, 1, 3'b000, 0, 0, 2, 3'b001, 3'b001, 0);
        add(0, 3'b000, 0, 1, 1, 2, 3'b000, 0, 0, 1, 3'b010, 3'b010, 0);
        add(0, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 3'b000, 0);

        // Burst-id mismatch sets a sticky error; beat with nothing outstanding is dropped.
        add(1, 3'b010, 1, 0, 0, 0, 3'b010, 0, 0, 0, 3'b000, 3'b000, 0);
        add(0, 3'b000, 1, 0, 0, 0, 3'b000, 1, 1, 0, 3'b000, 3'b000, 0);
        add(0, 3'b000, 0, 1, 0, 3, 3'b000, 0, 0, 1, 3'b010, 3'b000, 0);
        add(0, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 1, 3'b000, 3'b000, 1);
        add(0, 3'b000, 0, 1, 1, 1, 3'b000, 0, 0, 1, 3'b010, 3'b010, 1);
        add(0, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 3'b000, 1);
        add(0, 3'b000, 0, 1, 1, 0, 3'b000, 0, 0, 0, 3'b000, 3'b000, 1);
        add(0, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 3'b000, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            if (v.rst) do_reset(i);
            @(posedge clk);
            #1;
            dpat            = {8{32'hD000_0000 | 32'(i)}};
            req_valid       = v.rv;
            axi_in_arready  = v.ar;
            axi_in_valid    = v.iv;
            axi_in_finish   = v.fin;
            axi_in_burst_id = v.bid;
            axi_in_data     = dpat;
            @(negedge clk);
            exp_busy = (v.rv != 3'b000) || v.aval || (v.outst != 3'd0);
            chk("req_ready", i, 32'(req_ready), 32'(v.rdy));
            chk("axi_out_request_valid", i, 32'(axi_out_request_valid), 32'(v.aval));
            if (v.aval) begin
                chk("axi_out_sel", i, 32'(axi_out_sel), 32'(v.sel));
                chk("axi_out_BASE", i, axi_out_BASE, bases[v.sel]);
                chk("axi_out_num_size", i, {23'd0, axi_out_burst_num, axi_out_burst_size},
                    {23'd0, nums[v.sel], sizes[v.sel]});
            end
            chk("outstanding", i, 32'(outstanding), 32'(v.outst));
            chk("rsp_valid", i, 32'(rsp_valid), 32'(v.rspv));
            chk("rsp_last", i, 32'(rsp_last), 32'(v.rspl));
            chk("id_err", i, 32'(id_err), 32'(v.err));
            chk("busy", i, 32'(busy), 32'(exp_busy));
            if (v.iv) chk("rsp_data", i, 32'(rsp_data !== dpat), 32'd0);
        end

        // Asynchronous reset while a request is being offered, with a burst outstanding and id_err set.
        @(posedge clk); #1; quiet_inputs(); req_valid = 3'b001;
        @(negedge clk); chk("hs_ready_r0", 900, 32'(req_ready), 32'b001);
        @(posedge clk); #1; req_valid = 3'b000; axi_in_arready = 1'b1;
        @(negedge clk); chk("hs_issue_r0", 901, 32'(axi_out_request_valid), 32'd1);
        @(posedge clk); #1; req_valid = 3'b010; axi_in_arready = 1'b0;
        @(negedge clk); chk("hs_ready_r1", 902, 32'(req_ready), 32'b010);
        @(posedge clk); #1; req_valid = 3'b000;
        @(negedge clk);
        chk("hs_issue_r1", 903, {axi_out_request_valid, 28'd0, axi_out_sel}, {1'b1, 28'd0, 3'd1});
        chk("hs_pre_state", 903, {30'd0, id_err, outstanding != 3'd0}, 32'd3);
        #1 aresetn = 1'b0;
        #1;
        chk("async_rst_outputs", 904,
            {19'd0, req_ready, axi_out_request_valid, outstanding, id_err, busy, rsp_valid},
            32'd0);
        chk("async_rst_fields", 904, axi_out_BASE | {20'd0, axi_out_burst_num, axi_out_burst_size, axi_out_sel},
            32'd0);
        @(posedge clk);
        @(negedge clk); aresetn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_idle", 905, {28'd0, axi_out_request_valid, outstanding}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
